// File: rtl/cordic_phase_source.sv
// Head of the sine CORDIC pipeline: NCO with sample-rate divider, emitting rotator seed vectors and quarter codes.
// One cycle from tick to valid_o; no backpressure, as downstream rotators never stall.
module cordic_phase_source #(
  parameter int width_data  = 12,
  parameter int width_angle = 16,
  parameter int x_init      = 2487,
  parameter int div_ratio   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          sync_i,
  input  logic                          freq_we,
  input  logic [width_angle+1:0]        freq_i,
  input  logic [width_angle+1:0]        phase_ofs_i,
  output logic signed [width_data:0]    x_o,
  output logic signed [width_data:0]    y_o,
  output logic signed [width_angle:0]   z_o,
  output logic [1:0]                    quarter_o,
  output logic                          valid_o
);

  localparam int W = width_angle + 2;
  localparam logic [15:0] div_last = 16'(div_ratio - 1);
  localparam logic signed [width_data:0] x_seed = (width_data + 1)'(x_init);

  logic [W-1:0] acc;
  logic [W-1:0] freq_reg;
  logic [W-1:0] phase;
  logic [15:0]  div_cnt;
  logic         tick;

  assign tick  = en & ~sync_i & (div_cnt == div_last);
  // Truncation to W bits is the modulo-one-turn wrap.
  assign phase = acc + phase_ofs_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_reg <= '0;
    end else if (freq_we) begin
      freq_reg <= freq_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      div_cnt <= '0;
    end else if (sync_i) begin
      acc     <= '0;
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      if (tick) begin
        acc <= acc + freq_reg;
      end
    end
  end

  // Quarter goes down the pipe for sign/swap folding; rotators only see the in-quarter angle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_o       <= '0;
      y_o       <= '0;
      z_o       <= '0;
      quarter_o <= '0;
      valid_o   <= 1'b0;
    end else begin
      valid_o <= tick;
      if (tick) begin
        x_o       <= x_seed;
        y_o       <= '0;
        z_o       <= {1'b0, phase[W-3:0]};
        quarter_o <= phase[W-1:W-2];
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_source.sv
// Directed bench for cordic_phase_source: one instance at div_ratio=1, one at div_ratio=3, shared stimulus.
module tb_cordic_phase_source;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               sync_i;
  logic               freq_we;
  logic [17:0]        freq_i;
  logic [17:0]        phase_ofs_i;
  logic signed [12:0] x_o, y_o, x3, y3;
  logic signed [16:0] z_o, z3;
  logic [1:0]         quarter_o, q3;
  logic               valid_o, valid3;

  int n_assert = 0;
  int n_fail   = 0;
  int smp;

  always #5 clk = ~clk;

  cordic_phase_source dut (
    .clk(clk), .rst(rst), .en(en), .sync_i(sync_i), .freq_we(freq_we),
    .freq_i(freq_i), .phase_ofs_i(phase_ofs_i),
    .x_o(x_o), .y_o(y_o), .z_o(z_o), .quarter_o(quarter_o), .valid_o(valid_o)
  );

  cordic_phase_source #(.div_ratio(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .sync_i(sync_i), .freq_we(freq_we),
    .freq_i(freq_i), .phase_ofs_i(phase_ofs_i),
    .x_o(x3), .y_o(y3), .z_o(z3), .quarter_o(q3), .valid_o(valid3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag, input int p);
    chk({tag, "_vld"}, 32'(valid_o), 32'd1);
    chk({tag, "_q"}, 32'(quarter_o), 32'((p % 262144) / 65536));
    chk({tag, "_z"}, 32'(z_o), 32'(p % 65536));
  endtask

  task automatic resync(input logic [17:0] f);
    sync_i = 1'b1; freq_we = 1'b1; freq_i = f;
    step();
    chk("sync_novld", 32'(valid_o), 32'd0);
    sync_i = 1'b0; freq_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync_i = 1'b0; freq_we = 1'b0; freq_i = '0; phase_ofs_i = '0;
    repeat (3) step();
    chk("rst_x", 32'(x_o), 32'd0);
    chk("rst_y", 32'(y_o), 32'd0);
    chk("rst_z", 32'(z_o), 32'd0);
    chk("rst_q", 32'(quarter_o), 32'd0);
    chk("rst_vld", 32'(valid_o), 32'd0);
    chk("rst_vld3", 32'(valid3), 32'd0);

    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_vld", 32'(valid_o), 32'd0);
      chk("idle_vld3", 32'(valid3), 32'd0);
    end
    chk("idle_x", 32'(x_o), 32'd0);
    chk("idle_z", 32'(z_o), 32'd0);

    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("zero_vld", 32'(valid_o), 32'd1);
      chk("zero_x", 32'(x_o), 32'd2487);
      chk("zero_y", 32'(y_o), 32'd0);
      chk("zero_z", 32'(z_o), 32'd0);
      chk("zero_q", 32'(quarter_o), 32'd0);
    end

    // Stepping by a quarter of a quarter; full turn after 16 samples.
    en = 1'b0;
    resync(18'd16384);
    en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      chk_sample("step", k * 16384);
    end

    // Divider at 3, with a 5-cycle enable gap after the fourth sample.
    resync(18'd1000);
    smp = 0;
    for (int i = 1; i <= 20; i++) begin
      en = !(i >= 14 && i <= 18);
      step();
      if (i == 3 || i == 6 || i == 9 || i == 12 || i == 20) begin
        chk("div_vld", 32'(valid3), 32'd1);
        chk("div_z", 32'(z3), 32'(smp * 1000));
        smp++;
      end else begin
        chk("div_novld", 32'(valid3), 32'd0);
      end
    end
    en = 1'b1;

    // Offset plus increment wraps mod 2^18.
    phase_ofs_i = 18'h30000;
    resync(18'h20000);
    step(); chk_sample("wrap0", 32'h30000);
    step(); chk_sample("wrap1", 32'h10000);
    step(); chk_sample("wrap2", 32'h30000);

    // A tick in the write cycle still uses the old increment.
    phase_ofs_i = '0;
    resync(18'd16384);
    step(); chk_sample("wr0", 0);
    freq_we = 1'b1; freq_i = 18'd8192;
    step(); chk_sample("wr1", 16384);
    freq_we = 1'b0;
    step(); chk_sample("wr2", 32768);
    step(); chk_sample("wr3", 40960);

    // Sync combined with a frequency write.
    resync(18'd16384);
    for (int k = 0; k < 7; k++) begin
      step();
      chk_sample("pre", k * 16384);
    end
    resync(18'd8192);
    chk("sync_hold_z", 32'(z_o), 32'd32768);
    chk("sync_hold_q", 32'(quarter_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_sample("post", k * 8192);
    end

    // Reset mid-run clears outputs and frequency.
    rst = 1'b1; phase_ofs_i = 18'h25000;
    step();
    chk("mrst_x", 32'(x_o), 32'd0);
    chk("mrst_z", 32'(z_o), 32'd0);
    chk("mrst_q", 32'(quarter_o), 32'd0);
    chk("mrst_vld", 32'(valid_o), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_sample("rerun", 32'h25000);
      chk("rerun_x", 32'(x_o), 32'd2487);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
